// File: rtl/sseg_scan_ctrl_if.sv
// rtl/sseg_scan_ctrl_if.sv - display value valid/ready handshake bundle
interface sseg_scan_ctrl_if;
  logic [15:0] i_value;
  logic        i_valid;
  logic        o_ready;

  modport master (output i_value, output i_valid, input  o_ready);
  modport slave  (input  i_value, input  i_valid, output o_ready);
endinterface

// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - 4-digit multiplexed seven-segment scanner with blanking and PWM
// Optional: define SSEG_LZ_SUPPRESS_EN to blank leading zero digits (digit 0 always shown).
module sseg_scan_ctrl #(
  parameter int CLKS_PER_DIGIT = 1000,
  parameter int BLANK_CLKS     = 16,
  parameter int PWM_BITS       = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  sseg_scan_ctrl_if.slave     bus,
  input  logic [PWM_BITS-1:0] i_brightness,
  output logic [3:0]          o_sseg_enables,
  output logic [6:0]          o_sseg,
  output logic                o_frame_tick
);

  localparam int SW = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
  localparam logic [SW-1:0]       SLOT_LAST = SW'(CLKS_PER_DIGIT - 1);
  localparam logic [SW-1:0]       SLOT_PRE  = SW'(BLANK_CLKS - 1);
  localparam logic [PWM_BITS-1:0] PWM_FULL  = '1;

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  state_t              state;
  logic [SW-1:0]       slot_cnt;
  logic [1:0]          digit;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [15:0]         disp;
  logic [15:0]         pend;
  logic                pend_full;

  logic       slot_last;
  logic       frame_end;
  logic       accept;
  logic       suppress;
  logic       lit;
  logic [3:0] nibble;

  function automatic logic [6:0] hex_to_sseg(input logic [3:0] d);
    case (d)
      4'h0: hex_to_sseg = 7'h3F;
      4'h1: hex_to_sseg = 7'h06;
      4'h2: hex_to_sseg = 7'h5B;
      4'h3: hex_to_sseg = 7'h4F;
      4'h4: hex_to_sseg = 7'h66;
      4'h5: hex_to_sseg = 7'h6D;
      4'h6: hex_to_sseg = 7'h7D;
      4'h7: hex_to_sseg = 7'h07;
      4'h8: hex_to_sseg = 7'h7F;
      4'h9: hex_to_sseg = 7'h6F;
      4'hA: hex_to_sseg = 7'h77;
      4'hB: hex_to_sseg = 7'h7C;
      4'hC: hex_to_sseg = 7'h39;
      4'hD: hex_to_sseg = 7'h5E;
      4'hE: hex_to_sseg = 7'h79;
      default: hex_to_sseg = 7'h71;
    endcase
  endfunction

  assign slot_last   = (slot_cnt == SLOT_LAST);
  assign frame_end   = slot_last && (digit == 2'd3);
  assign accept      = bus.i_valid && !pend_full;
  assign bus.o_ready = !pend_full;
  assign nibble      = disp[{digit, 2'b00} +: 4];

`ifdef SSEG_LZ_SUPPRESS_EN
  always_comb begin
    suppress = 1'b0;
    case (digit)
      2'd3:    suppress = (disp[15:12] == 4'h0);
      2'd2:    suppress = (disp[15:8] == 8'h00);
      2'd1:    suppress = (disp[15:4] == 12'h000);
      default: suppress = 1'b0;
    endcase
  end
`else
  assign suppress = 1'b0;
`endif

  // Brightness is used live, so a change shows up on the very next output cycle.
  assign lit = (state == ST_ON) && !suppress &&
               ((i_brightness == PWM_FULL) || (pwm_cnt < i_brightness));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= ST_BLANK;
      slot_cnt       <= '0;
      digit          <= 2'd0;
      pwm_cnt        <= '0;
      disp           <= 16'h0000;
      pend           <= 16'h0000;
      pend_full      <= 1'b0;
      o_sseg_enables <= 4'b0000;
      o_sseg         <= 7'h00;
      o_frame_tick   <= 1'b0;
    end else begin
      o_sseg_enables <= lit ? (4'b0001 << digit) : 4'b0000;
      o_sseg         <= lit ? hex_to_sseg(nibble) : 7'h00;
      o_frame_tick   <= frame_end;

      if (slot_last) begin
        slot_cnt <= '0;
        digit    <= digit + 2'd1;
        state    <= ST_BLANK;
        pwm_cnt  <= pwm_cnt + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
        if (slot_cnt == SLOT_PRE) begin
          state   <= ST_ON;
          pwm_cnt <= '0;
        end else begin
          pwm_cnt <= pwm_cnt + 1'b1;
        end
      end

      // A full buffer blocks acceptance, so transfer and load never collide.
      if (frame_end && pend_full) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end
      if (accept) begin
        pend      <= bus.i_value;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb/tb_sseg_scan_ctrl.sv - randomized self-checking bench against a frame-arithmetic model
module tb_sseg_scan_ctrl;
  localparam int CPD   = 8;
  localparam int BL    = 2;
  localparam int PB    = 2;
  localparam int FRAME = 4 * CPD;

  logic          clk = 1'b0;
  logic          rst;
  logic [PB-1:0] bright;
  logic [3:0]    en;
  logic [6:0]    seg;
  logic          tick;

  sseg_scan_ctrl_if bus ();

  sseg_scan_ctrl #(.CLKS_PER_DIGIT(CPD), .BLANK_CLKS(BL), .PWM_BITS(PB)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .bus            (bus),
    .i_brightness   (bright),
    .o_sseg_enables (en),
    .o_sseg         (seg),
    .o_frame_tick   (tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: cycles since reset, shown value, pending value.
  int          n;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_full;
  logic [3:0]  x_en;
  logic [6:0]  x_seg;
  bit          x_tick;
  bit          armed = 1'b0;
  logic [3:0]  prev_en = 4'b0000;

  function automatic bit dark_digit(input int dig, input logic [15:0] v);
`ifdef SSEG_LZ_SUPPRESS_EN
    return (dig >= 1) && ((v >> (4 * dig)) == 16'h0000);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    int slot;
    int dig;
    int pwm;
    bit lit;
    bit rdy;
    if (rst) begin
      n = 0; m_full = 1'b0; m_disp = 16'h0; m_pend = 16'h0;
      x_en = 4'b0; x_seg = 7'h0; x_tick = 1'b0;
    end else begin
      slot = n % CPD;
      dig  = (n / CPD) % 4;
      pwm  = (slot - BL) % (1 << PB);
      lit  = (slot >= BL) && !dark_digit(dig, m_disp) &&
             ((bright == PB'((1 << PB) - 1)) || (pwm < int'(bright)));
      x_en   = lit ? (4'b0001 << dig) : 4'b0000;
      x_seg  = lit ? seg_tab[m_disp[4*dig +: 4]] : 7'h00;
      x_tick = (n % FRAME) == FRAME - 1;
      rdy    = !m_full;
      if (x_tick && m_full) begin
        m_disp = m_pend;
        m_full = 1'b0;
      end
      if (bus.i_valid && rdy) begin
        m_pend = bus.i_value;
        m_full = 1'b1;
      end
      n++;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check_eq("enables", en, x_en);
      check_eq("sseg", seg, x_seg);
      check_eq("frame_tick", tick, x_tick);
      check_eq("ready", bus.o_ready, !m_full);
      check_eq("onehot", $countones(en) <= 1, 1);
      check_eq("blank_sep", (en != 0) && (prev_en != 0) && (en != prev_en), 0);
      prev_en = en;
    end
  end

  task automatic run(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] v);
    int waited = 0;
    while (!bus.o_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.o_ready) check_eq("load_timeout", bus.o_ready, 1);
    bus.i_value = v;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    bright = 2'd3;
    bus.i_valid = 1'b0;
    bus.i_value = 16'h0000;
    @(posedge clk);
    armed = 1'b1;
    run(3);
    rst = 1'b0;

    // Idle at full brightness: digit 0..3 all show 0.
    run(70);

    // Mid-frame load, then an ignored second offer while pending is full.
    run(5);
    load(16'h1A3F);
    bus.i_value = 16'hBEEF;
    bus.i_valid = 1'b1;
    run(3);
    bus.i_valid = 1'b0;
    run(80);

    bright = 2'd1; run(40);
    bright = 2'd0; run(40);
    bright = 2'd2; run(40);
    bright = 2'd3;

    // Reset during digit 2 ON phase with a value pending.
    load(16'h5555);
    guard = 0;
    while ((n % FRAME) != 2 * CPD + BL + 2 && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    check_eq("reset_point_reached", (n % FRAME), 2 * CPD + BL + 2);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(70);

    foreach (seg_tab[i]) begin end
    load(16'h00A0); run(70);
    load(16'h0000); run(70);
    load(16'h000F); run(70);
    load(16'h0100); run(70);

    repeat (2000) begin
      bright      = PB'($urandom_range(0, 3));
      bus.i_valid = ($urandom_range(0, 15) == 0);
      bus.i_value = 16'($urandom);
      rst         = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.i_valid = 1'b0;
    run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Sequences a 4-digit multiplexed seven-segment display from a 16-bit hex value.
- Owns the digit scan timing, blanking between digits against ghosting, and PWM brightness.
- Decodes hex to segments and drives one-hot digit enables directly to the display pins.
- Accepts new display values through a valid/ready handshake. Updates apply only at frame boundaries, so a frame never tears.

Parameters:
- CLKS_PER_DIGIT, 1000: length of one digit slot in i_clk cycles; minimum BLANK_CLKS+2.
- BLANK_CLKS, 16: cycles at the start of each slot with all enables and segments off; minimum 1.
- PWM_BITS, 4: width of the brightness control and the PWM counter.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_value  in  16  hex value; nibble k goes to digit k.
- i_valid  in  1  i_value is offered.
- o_ready  out  1  block can accept a value (pending buffer empty).
- i_brightness  in  PWM_BITS  0 = dark; all-ones = full on.
- o_sseg_enables  out  4  one-hot digit enable, active-high; bit k = digit k.
- o_sseg  out  7  segments, active-high; bit0=a … bit6=g.
- o_frame_tick  out  1  one-cycle pulse at the end of each full 4-digit frame.

Behaviour:
- Reset and clock: reset is i_reset, synchronous, active-high; clock is i_clk.
- Reset values:
  - digit index 0, slot counter 0, PWM counter 0.
  - display register 0, pending buffer empty.
  - o_sseg_enables=0, o_sseg=0, o_frame_tick=0, o_ready=1.
- Reset mid-operation: a reset asserted mid-frame takes effect on the next edge and discards any pending value. The scan restarts at digit 0 in BLANK.
- Slot counter: counts 0..CLKS_PER_DIGIT-1, then wraps to 0. On each wrap, digit index increments 0→1→2→3→0.
- State per slot:
  - BLANK while slot_cnt < BLANK_CLKS.
  - ON while slot_cnt ≥ BLANK_CLKS.
  - BLANK→ON when slot_cnt reaches BLANK_CLKS; ON→BLANK on slot wrap.
- PWM counter: free-running, PWM_BITS wide, reset to 0 on every BLANK→ON transition.
- Digit lit condition: ON and (i_brightness==all-ones or pwm_cnt < i_brightness).
- Outputs are registered, with 1-cycle latency from the internal state:
  - Digit lit: o_sseg_enables = 1<<digit; o_sseg = hex decode of display nibble[digit].
  - Otherwise: both outputs are 0.
- Hex decode (gfedcba):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Handshake and buffering:
  - o_ready = pending buffer empty.
  - i_valid && o_ready loads i_value into pending and sets it full.
  - i_valid while o_ready=0 is ignored. The source must hold i_value until it sees ready.
- Frame boundary: the cycle where digit==3 and slot_cnt==CLKS_PER_DIGIT-1. On that edge:
  - internal frame_end is asserted; o_frame_tick goes high on the next cycle, registered.
  - if pending is full, pending moves to the display register and pending empties.
  - the next slot (digit 0) shows the new value.
- Simultaneous i_valid with an empty buffer at the frame boundary: the value goes into pending only and is displayed one frame later. There is no bypass.
- Brightness: i_brightness is sampled every cycle. A change takes effect within one cycle, with no resynchronisation to the slot.
- At most one enable bit is ever high. A blank cycle always separates two different enables.

Optional Feature:
- Macro: SSEG_LZ_SUPPRESS_EN.
- Defined: leading-zero suppression. Digit k is forced dark (enable and segments 0) when nibble k==0 and all higher nibbles ==0, for k=3..1. Digit 0 is never suppressed, so value 0 shows a single "0". Slot timing and o_frame_tick are unchanged.
- Undefined: all four digits always display, including leading zeros.

Test Plan:
All scenarios use CLKS_PER_DIGIT=8, BLANK_CLKS=2, PWM_BITS=2.
1. Reset, then i_brightness=3, no load.
   - Cycles 0-1 after reset: enables=0.
   - Cycles 2-7: enables=0001, sseg=3F.
   - Then 2 blank cycles and digit 1; o_frame_tick pulses once every 32 cycles.
2. Load 16'h1A3F mid-frame (o_ready 1→0).
   - Current frame is unchanged.
   - After o_frame_tick: digits 0..3 show 71,4F,77,06.
   - o_ready returns to 1 at the transfer edge.
3. Second i_valid while pending is full → ignored. The first value is displayed and o_ready stays low until the frame boundary.
4. i_brightness=1 → each digit is lit in 2 of its 6 ON cycles (pwm_cnt==0 only). i_brightness=0 → enables stay 0 for an entire frame.
5. Assert i_reset during the ON phase of digit 2 → outputs 0 next cycle, pending cleared, and the scan restarts at digit 0 showing 3F.
6. With SSEG_LZ_SUPPRESS_EN, load 16'h00A0 → digits 3 and 2 dark, digit 1=77, digit 0=3F. Load 16'h0000 → only digit 0 lit, showing 3F.
